pipe_stage_reg: RTL

//   Parametrised pipeline-stage register with valid/ready handshake, optional skid

---
 rtl/pipe_stage_reg_pkg.sv | 32 +++
 rtl/pipe_stage_reg_if.sv | 16 +
 rtl/pipe_stage_reg_entry.sv | 60 ++++++
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: default widths, MEM/WB field layout and control split.
package pipe_pkg;

   localparam int PIPE_DATA_W  = 32;
   localparam int PIPE_NFIELDS = 5;
   localparam int WB_W         = 6;
   localparam int RCT_W        = 3;
   localparam int MEMWB_CTRL_W = WB_W + RCT_W;

   localparam int F_PC4     = 0;
   localparam int F_MEMDATA = 1;
   localparam int F_RES     = 2;
   localparam int F_INST    = 3;
   localparam int F_HILO    = 4;

   // Member order is MSB first, so pc4 lands in field 0 of the flat payload.
   typedef struct packed {
      logic [PIPE_DATA_W-1:0] hilo;
      logic [PIPE_DATA_W-1:0] inst;
      logic [PIPE_DATA_W-1:0] res;
      logic [PIPE_DATA_W-1:0] mem_data;
      logic [PIPE_DATA_W-1:0] pc4;
   } memwb_payload_t;

   function automatic logic [PIPE_DATA_W-1:0] get_field(
      input logic [PIPE_NFIELDS*PIPE_DATA_W-1:0] payload,
      input int                                  idx
   );
      return payload[idx*PIPE_DATA_W +: PIPE_DATA_W];
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// One valid/ready beat channel (payload + control) between pipeline stages.
interface pipe_stage_reg_if #(
   parameter int DATA_W  = 32,
   parameter int NFIELDS = 5,
   parameter int CTRL_W  = 9
);

   logic                      valid;
   logic                      ready;
   logic [NFIELDS*DATA_W-1:0] data;
   logic [CTRL_W-1:0]         ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/pipe_stage_reg_entry.sv
// pipe_stage_entry: one valid + payload + control register with load, drop and clear.
module pipe_stage_entry #(
   parameter int PW           = 160,
   parameter int CTRL_W       = 9,
   parameter bit CLR_ON_FLUSH = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic              drop,
   input  logic [PW-1:0]     load_data,
   input  logic [CTRL_W-1:0] load_ctrl,
   output logic              valid,
   output logic [PW-1:0]     data,
   output logic [CTRL_W-1:0] ctrl
);

   logic              valid_d, valid_q;
   logic [PW-1:0]     data_d, data_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;

   // Control is zeroed whenever the entry goes empty; payload is only zeroed by clear.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (clear) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         if (CLR_ON_FLUSH) begin
            data_d = '0;
         end
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         ctrl_d  = load_ctrl;
      end else if (drop) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ctrl_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry and sync flush.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt/bubble_cnt counter outputs.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W       = PIPE_DATA_W,
   parameter int NFIELDS      = PIPE_NFIELDS,
   parameter int CTRL_W       = MEMWB_CTRL_W,
   parameter bit SKID         = 1'b1,
   parameter bit CLR_ON_FLUSH = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   pipe_stage_reg_if.slave  in_if,
   pipe_stage_reg_if.master out_if
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [31:0]      stall_cnt,
   output logic [31:0]      bubble_cnt
`endif
);

   localparam int PW = NFIELDS * DATA_W;

   logic              main_valid, skid_valid;
   logic [PW-1:0]     main_data, skid_data, main_src_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;
   logic              accept, main_load, main_drop, skid_load, skid_drop;

   // With a skid entry in_ready is purely registered; without it, it looks through out_ready.
   assign in_if.ready = SKID ? (~skid_valid & ~rst)
                             : ((~main_valid | out_if.ready) & ~rst);
   assign accept      = in_if.valid & in_if.ready;

   always_comb begin
      main_load     = 1'b0;
      main_drop     = 1'b0;
      skid_load     = 1'b0;
      skid_drop     = 1'b0;
      main_src_data = skid_valid ? skid_data : in_if.data;
      main_src_ctrl = skid_valid ? skid_ctrl : in_if.ctrl;
      if (~main_valid | out_if.ready) begin
         if (skid_valid) begin
            main_load = 1'b1;
            skid_drop = 1'b1;
         end else if (accept) begin
            main_load = 1'b1;
         end else if (main_valid) begin
            main_drop = 1'b1;
         end
      end else if (accept) begin
         skid_load = 1'b1;
      end
   end

   pipe_stage_entry #(
      .PW(PW), .CTRL_W(CTRL_W), .CLR_ON_FLUSH(CLR_ON_FLUSH)
   ) u_main (
      .clk(clk), .rst(rst), .clear(flush),
      .load(main_load), .drop(main_drop),
      .load_data(main_src_data), .load_ctrl(main_src_ctrl),
      .valid(main_valid), .data(main_data), .ctrl(main_ctrl)
   );

   generate
      if (SKID) begin : g_skid
         pipe_stage_entry #(
            .PW(PW), .CTRL_W(CTRL_W), .CLR_ON_FLUSH(CLR_ON_FLUSH)
         ) u_skid (
            .clk(clk), .rst(rst), .clear(flush),
            .load(skid_load), .drop(skid_drop),
            .load_data(in_if.data), .load_ctrl(in_if.ctrl),
            .valid(skid_valid), .data(skid_data), .ctrl(skid_ctrl)
         );
      end else begin : g_no_skid
         logic unused_skid;
         assign skid_valid  = 1'b0;
         assign skid_data   = '0;
         assign skid_ctrl   = '0;
         assign unused_skid = skid_load | skid_drop;
      end
   endgenerate

   assign out_if.valid = main_valid;
   assign out_if.data  = main_data;
   assign out_if.ctrl  = main_ctrl;

`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q;

   // Both counters saturate and survive flush; only reset clears them.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (main_valid & ~out_if.ready & (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (~main_valid & ~flush & (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
